// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM ramp sequencer.
// The state encoding and step-size sentinel are used by the controller and the bench.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } pwm_ramp_state_t;

  // A zero step size means "jump straight to the target in one update".
  localparam int STEP_JUMP = 0;

endpackage

// File: rtl/pwm_duty_stepper.sv
// Combinational next-duty calculation: moves cur toward target by step and saturates at
// the target. Sums and differences are one bit wider so nothing wraps near full scale.
module pwm_duty_stepper
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic [WIDTH-1:0] i_target,
  input  logic [WIDTH-1:0] i_step,
  output logic [WIDTH-1:0] o_next,
  output logic             o_at_target
);

  logic [WIDTH:0] w_sum_up;
  logic [WIDTH:0] w_gap_down;
  logic [WIDTH:0] w_target_ext;
  logic [WIDTH:0] w_step_ext;

  assign w_target_ext = {1'b0, i_target};
  assign w_step_ext   = {1'b0, i_step};
  assign w_sum_up     = {1'b0, i_cur} + w_step_ext;
  assign w_gap_down   = {1'b0, i_cur} - w_target_ext;

  always_comb begin
    o_next = i_target;
    if (i_step == WIDTH'(STEP_JUMP)) begin
      o_next = i_target;
    end else if (i_cur < i_target) begin
      if (w_sum_up >= w_target_ext) begin
        o_next = i_target;
      end else begin
        o_next = w_sum_up[WIDTH-1:0];
      end
    end else if (i_cur > i_target) begin
      // w_gap_down is only meaningful here, where cur is strictly above target.
      if (w_step_ext >= w_gap_down) begin
        o_next = i_target;
      end else begin
        o_next = i_cur - i_step;
      end
    end
  end

  assign o_at_target = (o_next == i_target);

endmodule

// File: rtl/pwm_ramp_controller.sv
// Ramp sequencer in front of a PWM generator: accepts a ramp command and walks the duty
// toward its target, issuing one update_parameters strobe per step on period boundaries.
module pwm_ramp_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_WIDTH  = 8,
  parameter int INIT_PERIOD = 255,
  parameter int INIT_DUTY   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WIDTH-1:0]      cmd_period,
  input  logic [WIDTH-1:0]      cmd_duty,
  input  logic [WIDTH-1:0]      cmd_step,
  input  logic [HOLD_WIDTH-1:0] cmd_hold,
  input  logic                  abort,
  input  logic                  period_start,
  output logic [WIDTH-1:0]      pwm_period,
  output logic [WIDTH-1:0]      pwm_duty_cycle,
  output logic                  update_parameters,
  output logic                  busy,
  output logic                  done
);

  pwm_ramp_state_t       r_state;
  logic [WIDTH-1:0]      r_period_lat;
  logic [WIDTH-1:0]      r_target;
  logic [WIDTH-1:0]      r_step;
  logic [HOLD_WIDTH-1:0] r_hold;
  logic [HOLD_WIDTH-1:0] r_hold_cnt;
  logic [WIDTH-1:0]      r_pwm_period;
  logic [WIDTH-1:0]      r_pwm_duty;
  logic                  r_update;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cmd_ready;

  logic [WIDTH-1:0]      w_cmd_target;
  logic [WIDTH-1:0]      w_next_duty;
  logic                  w_at_target;
  logic                  w_accept;
  logic                  w_step_due;

  // The duty can never exceed the period, so the target is clamped at acceptance.
  assign w_cmd_target = (cmd_duty > cmd_period) ? cmd_period : cmd_duty;
  assign w_accept     = cmd_valid && r_cmd_ready;
  assign w_step_due   = period_start && (r_hold_cnt == r_hold);

  pwm_duty_stepper #(
    .WIDTH(WIDTH)
  ) u_stepper (
    .i_cur       (r_pwm_duty),
    .i_target    (r_target),
    .i_step      (r_step),
    .o_next      (w_next_duty),
    .o_at_target (w_at_target)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_period_lat <= WIDTH'(INIT_PERIOD);
      r_target     <= WIDTH'(INIT_DUTY);
      r_step       <= '0;
      r_hold       <= '0;
      r_hold_cnt   <= '0;
      r_pwm_period <= WIDTH'(INIT_PERIOD);
      r_pwm_duty   <= WIDTH'(INIT_DUTY);
      r_update     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cmd_ready  <= 1'b1;
    end else begin
      r_update <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_period_lat <= cmd_period;
            r_target     <= w_cmd_target;
            r_step       <= cmd_step;
            r_hold       <= cmd_hold;
            r_hold_cnt   <= '0;
            r_busy       <= 1'b1;
            r_cmd_ready  <= 1'b0;
            r_state      <= RAMP;
          end
        end
        RAMP: begin
          if (abort) begin
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end else if (w_step_due) begin
            r_pwm_period <= r_period_lat;
            r_pwm_duty   <= w_next_duty;
            r_update     <= 1'b1;
            r_hold_cnt   <= '0;
            if (w_at_target) begin
              r_busy  <= 1'b0;
              r_state <= DONE;
            end
          end else if (period_start) begin
            r_hold_cnt <= r_hold_cnt + HOLD_WIDTH'(1);
          end
        end
        DONE: begin
          // cmd_ready is raised from IDLE one cycle later so it trails done.
          if (abort) begin
            r_cmd_ready <= 1'b1;
          end else begin
            r_done <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready         = r_cmd_ready;
  assign pwm_period        = r_pwm_period;
  assign pwm_duty_cycle    = r_pwm_duty;
  assign update_parameters = r_update;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Scoreboard bench for pwm_ramp_controller: expected updates are queued when a command
// is issued and compared against every update_parameters strobe the DUT emits.
module tb_pwm_ramp_controller;
  import pwm_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          abort = 1'b0;
  logic          period_start = 1'b0;
  logic [W-1:0]  cmd_period = '0;
  logic [W-1:0]  cmd_duty = '0;
  logic [W-1:0]  cmd_step = '0;
  logic [HW-1:0] cmd_hold = '0;
  logic          cmd_ready;
  logic [W-1:0]  pwm_period;
  logic [W-1:0]  pwm_duty_cycle;
  logic          update_parameters;
  logic          busy;
  logic          done;

  pwm_ramp_controller #(
    .WIDTH(W), .HOLD_WIDTH(HW), .INIT_PERIOD(255), .INIT_DUTY(0)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_duty(cmd_duty), .cmd_step(cmd_step), .cmd_hold(cmd_hold),
    .abort(abort), .period_start(period_start), .pwm_period(pwm_period),
    .pwm_duty_cycle(pwm_duty_cycle), .update_parameters(update_parameters),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] period;
    logic [W-1:0] duty;
    int           gap;
    bit           last;
  } upd_t;

  upd_t sb[$];
  upd_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Generator stand-in: one period_start pulse every 8 clocks.
  int ps_phase = 0;
  always @(posedge clk) begin
    #1;
    ps_phase = (ps_phase + 1) % 8;
    period_start = (ps_phase == 0);
  end

  bit mon_en = 1'b0;
  int model_period = 255;
  int model_duty = 0;
  int sched_duty = 0;
  int ps_since = 0;
  bit exp_done = 1'b0;
  bit exp_ready_next = 1'b0;
  int upd_count = 0;
  int done_count = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check_val("done", done, exp_done);
      if (exp_done) begin
        check_val("ready_at_done", cmd_ready, 0);
        done_count++;
      end
      if (exp_ready_next) check_val("ready_after_done", cmd_ready, 1);
      exp_ready_next = exp_done;
      exp_done = 1'b0;
      if (update_parameters) begin
        check_val("update_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check_val("upd_period", pwm_period, mon_e.period);
          check_val("upd_duty", pwm_duty_cycle, mon_e.duty);
          check_val("upd_gap", ps_since, mon_e.gap);
          $display("update #%0d period=%0d duty=%0d gap=%0d", upd_count, pwm_period,
                   pwm_duty_cycle, ps_since);
          model_period = int'(mon_e.period);
          model_duty   = int'(mon_e.duty);
          exp_done     = mon_e.last;
        end
        upd_count++;
        ps_since = 0;
      end else begin
        check_val("period_stable", pwm_period, model_period);
        check_val("duty_stable", pwm_duty_cycle, model_duty);
      end
      if (cmd_valid && cmd_ready) ps_since = 0;
      else if (period_start) ps_since++;
    end
  end

  task automatic send_cmd(input int p, input int d, input int s, input int h, input bit align);
    int tgt, cur, nxt, guard;
    upd_t e;
    @(posedge clk); #2;
    guard = 0;
    while (align && !period_start && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    cmd_period = W'(p); cmd_duty = W'(d); cmd_step = W'(s); cmd_hold = HW'(h);
    cmd_valid = 1'b1;
    @(negedge clk);
    check_val("ready_on_send", cmd_ready, 1);
    $display("cmd period=%0d duty=%0d step=%0d hold=%0d from=%0d", p, d, s, h, sched_duty);
    tgt = (d < p) ? d : p;
    cur = sched_duty;
    do begin
      if (s == 0) nxt = tgt;
      else if (cur < tgt) nxt = (tgt - cur <= s) ? tgt : cur + s;
      else if (cur > tgt) nxt = (cur - tgt <= s) ? tgt : cur - s;
      else nxt = tgt;
      e.period = W'(p); e.duty = W'(nxt); e.gap = h + 1; e.last = (nxt == tgt);
      sb.push_back(e);
      cur = nxt;
    end while (cur != tgt);
    sched_duty = tgt;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_count <= base && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("ramp_done", done_count > base, 1);
    check_val("sb_drained", sb.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_upd(input int target);
    int n = 0;
    while (upd_count < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("upd_reached", upd_count >= target, 1);
  endtask

  task automatic run_ramp(input int p, input int d, input int s, input int h, input bit align);
    int base;
    base = done_count;
    send_cmd(p, d, s, h, align);
    wait_done(base);
  endtask

  task automatic check_defaults(input string tag);
    check_val({tag, "_period"}, pwm_period, 255);
    check_val({tag, "_duty"}, pwm_duty_cycle, 0);
    check_val({tag, "_update"}, update_parameters, 0);
    check_val({tag, "_ready"}, cmd_ready, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #2;
    check_defaults("in_reset");
    reset = 1'b1;
    @(negedge clk);
    check_defaults("after_reset");
    mon_en = 1'b1;

    run_ramp(8, 8, 3, 0, 1'b0);      // 3, 6, 8
    run_ramp(8, 1, 2, 1, 1'b0);      // 6, 4, 2, 1 two periods apart
    run_ramp(10, 20, 0, 0, 1'b0);    // clamp + jump: 10
    run_ramp(12, 10, 5, 0, 1'b1);    // equal target, coincident period_start
    run_ramp(255, 250, 200, 0, 1'b0); // 210, 250 without wrap
    run_ramp(255, 5, 200, 0, 1'b1);   // 50, 5
    run_ramp(8, 0, 0, 0, 1'b0);      // back to 0

    // Abort after the second update of a 0->8 step-2 ramp.
    base = upd_count;
    send_cmd(8, 8, 2, 0, 1'b0);
    wait_upd(base + 2);
    @(posedge clk); #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    sb.delete();
    sched_duty = model_duty;
    @(negedge clk);
    check_val("abort_ready", cmd_ready, 1);
    check_val("abort_busy", busy, 0);
    check_val("abort_duty", pwm_duty_cycle, 4);
    repeat (40) @(negedge clk);

    // Command presented mid-ramp must be ignored.
    base = done_count;
    send_cmd(8, 0, 1, 1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    cmd_valid = 1'b1; cmd_period = 8'd50; cmd_duty = 8'd200; cmd_step = 8'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("ready_while_busy", cmd_ready, 0);
      check_val("busy_in_ramp", busy, 1);
    end
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    wait_done(base);

    // Asynchronous reset in the middle of a ramp.
    base = upd_count;
    send_cmd(8, 8, 1, 0, 1'b0);
    wait_upd(base + 1);
    @(posedge clk); #3;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check_defaults("async_reset");
    sb.delete();
    model_period = 255; model_duty = 0; sched_duty = 0;
    exp_done = 1'b0; exp_ready_next = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    check_defaults("post_reset");
    mon_en = 1'b1;
    run_ramp(8, 2, 1, 0, 1'b0);      // 1, 2

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
